dut_result_uart: RTL

- Downstream stage for the DSP hardware-test DUTs.
- Captures the registered 54-bit Z result of a MULTADDSUB18X18 DUT on a capture pulse.
- Streams the captured value to the host as an ASCII hex line over an 8N1 UART TX pin.
- The host script compares each line against its software model of the primitive.

---
 rtl/dut_result_uart.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/dut_result_uart.sv
// dut_result_uart: captures the 54-bit Z result of a DSP DUT on a capture
// pulse and streams it to the host as an uppercase ASCII hex line ending in
// CR LF, over an 8N1 UART transmitter.
// Optional feature macro: DUT_RESULT_UART_SEQNUM_EN prefixes each line with a
// two-digit hex sequence number and a space (19 characters per line).
module dut_result_uart #(
    parameter int CLKS_PER_BIT = 104,
    parameter int Z_WIDTH      = 54
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               capture,
    input  logic [Z_WIDTH-1:0] z,
    output logic               uart_tx,
    output logic               busy,
    output logic [7:0]         overrun
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef DUT_RESULT_UART_SEQNUM_EN
    // Line: 2 sequence digits, space, 14 result digits, CR, LF.
    localparam logic [4:0] LAST_IDX = 5'd18;
    localparam logic [4:0] Z_OFS    = 5'd3;
`else
    // Line: 14 result digits, CR, LF.
    localparam logic [4:0] LAST_IDX = 5'd15;
    localparam logic [4:0] Z_OFS    = 5'd0;
`endif

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_bit;
    logic [4:0]         r_idx;
    logic [Z_WIDTH-1:0] r_zl;
    logic               r_tx;
    logic [7:0]         r_ovr;

    logic               w_accept;
    logic               w_drop;
    logic               w_bit_end;
    logic [55:0]        w_zext;
    logic [4:0]         w_dig;
    logic [3:0]         w_nib;
    logic [7:0]         w_char;

`ifdef DUT_RESULT_UART_SEQNUM_EN
    logic [7:0]         r_seq;
    logic [7:0]         r_seq_l;
`endif

    // Map a nibble to its uppercase ASCII hex digit.
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign w_accept  = capture && (r_state == S_IDLE);
    assign w_drop    = capture && (r_state != S_IDLE);
    assign w_bit_end = (r_cnt == CNT_LAST);
    assign w_zext    = 56'(r_zl);
    // Digit position within the result field; wraps out of range for prefix chars.
    assign w_dig     = r_idx - Z_OFS;

    // Character byte for the current line position, derived from the shadow register.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_nib = 4'h0;
        for (int i = 0; i < 14; i++) begin
            if (w_dig == 5'(i)) w_nib = w_zext[4*(13-i) +: 4];
        end
        w_char = hex_ascii(w_nib);
        if (r_idx == LAST_IDX - 5'd1) begin
            w_char = 8'h0D;
        end else if (r_idx == LAST_IDX) begin
            w_char = 8'h0A;
        end
`ifdef DUT_RESULT_UART_SEQNUM_EN
        if (r_idx == 5'd0) begin
            w_char = hex_ascii(r_seq_l[7:4]);
        end else if (r_idx == 5'd1) begin
            w_char = hex_ascii(r_seq_l[3:0]);
        end else if (r_idx == 5'd2) begin
            w_char = 8'h20;
        end
`endif
    end

    // Shadow copy of z taken on an accepted capture; held for the whole frame.
    always_ff @(posedge clk) begin
        // NOTE: pure data register with no reset; it is only read while busy, after an accept loaded it.
        if (w_accept) r_zl <= z;
    end

    // Frame sequencer: START, 8 DATA bits LSB first, STOP per character, characters back-to-back.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_idx   <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_tx    <= w_char[0];
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                            r_tx  <= w_char[r_bit + 3'd1];
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_idx == LAST_IDX) begin
                            r_tx    <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_idx   <= r_idx + 5'd1;
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Saturating count of captures that arrived while a frame was in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovr <= '0;
        end else if (w_drop && (r_ovr != 8'hFF)) begin
            r_ovr <= r_ovr + 8'd1;
        end
    end

`ifdef DUT_RESULT_UART_SEQNUM_EN
    // Sequence number: latch the current value for this line, then advance (wraps at 255).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seq   <= '0;
            r_seq_l <= '0;
        end else if (w_accept) begin
            r_seq_l <= r_seq;
            r_seq   <= r_seq + 8'd1;
        end
    end
`endif

    assign uart_tx = r_tx;
    assign busy    = (r_state != S_IDLE);
    assign overrun = r_ovr;

endmodule
